// File: rtl/prf_pkg.sv
// Shared physical-register types for rename, reservation stations, FUs and the PRF.
// Pure declarations: no logic, no latency, no flow control.
package prf_pkg;
  localparam int NUM_PREGS = 128;
  localparam int XLEN      = 32;
  localparam int PW        = $clog2(NUM_PREGS);

  typedef logic [PW-1:0]   preg_t;
  typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/prf_bypass_mux.sv
// One read operand: same-cycle writeback bypass over array data and ready bit.
// Combinational (0 cycles); never stalls, so there is no backpressure.
module prf_bypass_mux
  import prf_pkg::*;
#(
  parameter int NUM_WR = 3
) (
  input  logic [NUM_WR-1:0] i_wr_en,
  input  preg_t             i_wr_pd   [NUM_WR],
  input  word_t             i_wr_data [NUM_WR],
  input  preg_t             i_tag,
  input  word_t             i_arr_data,
  input  logic              i_arr_rdy,
  output word_t             o_data,
  output logic              o_rdy
);

  always_comb begin
    o_data = i_arr_data;
    o_rdy  = i_arr_rdy;
    // Ascending scan so the highest-indexed matching port wins.
    for (int w = 0; w < NUM_WR; w++) begin
      if (i_wr_en[w] && (i_wr_pd[w] == i_tag)) begin
        o_data = i_wr_data[w];
        o_rdy  = 1'b1;
      end
    end
    if (i_tag == '0) begin
      o_data = '0;
      o_rdy  = 1'b1;
    end
  end

endmodule

// File: rtl/prf_scoreboard.sv
// Physical register file with per-register ready scoreboard; writes bypass to reads in 0 cycles,
// stored at the edge. No handshakes: every input is sampled each cycle and nothing stalls.
module prf_scoreboard
  import prf_pkg::*;
#(
  parameter int NUM_WR    = 3,
  parameter int NUM_RD    = 3,
  parameter int NUM_ALLOC = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NUM_WR-1:0]    i_wr_en,
  input  preg_t                i_wr_pd    [NUM_WR],
  input  word_t                i_wr_data  [NUM_WR],
  input  logic [NUM_RD-1:0]    i_rd_en,
  input  preg_t                i_rd_ps1   [NUM_RD],
  input  preg_t                i_rd_ps2   [NUM_RD],
  output word_t                o_rd_data1 [NUM_RD],
  output word_t                o_rd_data2 [NUM_RD],
  output logic [NUM_RD-1:0]    o_rd_rdy1,
  output logic [NUM_RD-1:0]    o_rd_rdy2,
  input  logic [NUM_ALLOC-1:0] i_alloc_en,
  input  preg_t                i_alloc_pd [NUM_ALLOC],
  input  logic                 i_flush,
  output logic                 o_collision
);

  word_t                r_data [NUM_PREGS];
  logic [NUM_PREGS-1:0] r_rdy;
  logic                 r_collision;
  logic [NUM_PREGS-1:0] w_rdy_nxt;
  logic                 w_collide;

  // Priority for the ready bit: writeback sets, allocation clears, flush sets everything.
  always_comb begin
    w_rdy_nxt = r_rdy;
    for (int w = 0; w < NUM_WR; w++) begin
      if (i_wr_en[w]) w_rdy_nxt[i_wr_pd[w]] = 1'b1;
    end
    for (int a = 0; a < NUM_ALLOC; a++) begin
      if (i_alloc_en[a]) w_rdy_nxt[i_alloc_pd[a]] = 1'b0;
    end
    if (i_flush) w_rdy_nxt = '1;
    w_rdy_nxt[0] = 1'b1;
  end

  always_comb begin
    w_collide = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (i_wr_en[i] && i_wr_en[j] && (i_wr_pd[i] == i_wr_pd[j]) && (i_wr_pd[i] != '0))
          w_collide = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < NUM_PREGS; k++) r_data[k] <= '0;
      r_rdy       <= '1;
      r_collision <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (i_wr_en[w] && (i_wr_pd[w] != '0)) r_data[i_wr_pd[w]] <= i_wr_data[w];
      end
      r_rdy       <= w_rdy_nxt;
      r_collision <= r_collision | w_collide;
    end
  end

  assign o_collision = r_collision;

  word_t             w_byp_data1 [NUM_RD];
  word_t             w_byp_data2 [NUM_RD];
  logic [NUM_RD-1:0] w_byp_rdy1;
  logic [NUM_RD-1:0] w_byp_rdy2;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    prf_bypass_mux #(.NUM_WR(NUM_WR)) u_byp1 (
      .i_wr_en    (i_wr_en),
      .i_wr_pd    (i_wr_pd),
      .i_wr_data  (i_wr_data),
      .i_tag      (i_rd_ps1[p]),
      .i_arr_data (r_data[i_rd_ps1[p]]),
      .i_arr_rdy  (r_rdy[i_rd_ps1[p]]),
      .o_data     (w_byp_data1[p]),
      .o_rdy      (w_byp_rdy1[p])
    );

    prf_bypass_mux #(.NUM_WR(NUM_WR)) u_byp2 (
      .i_wr_en    (i_wr_en),
      .i_wr_pd    (i_wr_pd),
      .i_wr_data  (i_wr_data),
      .i_tag      (i_rd_ps2[p]),
      .i_arr_data (r_data[i_rd_ps2[p]]),
      .i_arr_rdy  (r_rdy[i_rd_ps2[p]]),
      .o_data     (w_byp_data2[p]),
      .o_rdy      (w_byp_rdy2[p])
    );

    // Read outputs are forced low for the whole time reset is held.
    assign o_rd_data1[p] = (i_reset_n && i_rd_en[p]) ? w_byp_data1[p] : '0;
    assign o_rd_data2[p] = (i_reset_n && i_rd_en[p]) ? w_byp_data2[p] : '0;
    assign o_rd_rdy1[p]  = i_reset_n & w_byp_rdy1[p];
    assign o_rd_rdy2[p]  = i_reset_n & w_byp_rdy2[p];
  end

endmodule

// File: tb/tb_prf_scoreboard.sv
// Bench for prf_scoreboard: directed scenarios plus a short randomized run against a reference model.
module tb_prf_scoreboard;
  import prf_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [2:0] wr_en;
  preg_t      wr_pd   [3];
  word_t      wr_data [3];
  logic [2:0] rd_en;
  preg_t      ps1 [3];
  preg_t      ps2 [3];
  word_t      d1  [3];
  word_t      d2  [3];
  logic [2:0] r1, r2;
  logic [0:0] alloc_en;
  preg_t      alloc_pd [1];
  logic       flush;
  logic       collision;

  prf_scoreboard #(.NUM_WR(3), .NUM_RD(3), .NUM_ALLOC(1)) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_wr_en     (wr_en),
    .i_wr_pd     (wr_pd),
    .i_wr_data   (wr_data),
    .i_rd_en     (rd_en),
    .i_rd_ps1    (ps1),
    .i_rd_ps2    (ps2),
    .o_rd_data1  (d1),
    .o_rd_data2  (d2),
    .o_rd_rdy1   (r1),
    .o_rd_rdy2   (r2),
    .i_alloc_en  (alloc_en),
    .i_alloc_pd  (alloc_pd),
    .i_flush     (flush),
    .o_collision (collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    port;
    bit    op2;
    word_t d;
    logic  r;
    string nm;
  } exp_t;

  exp_t  q[$];
  int    n_cmp;
  int    n_err;
  logic  exp_coll;

  word_t m_data [16];
  logic  m_rdy  [16];
  logic  m_coll;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en       = '0;
    rd_en       = '0;
    alloc_en    = '0;
    alloc_pd[0] = '0;
    flush       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_pd[i]   = '0;
      wr_data[i] = '0;
      ps1[i]     = '0;
      ps2[i]     = '0;
    end
  endtask

  task automatic wr(input int p, input preg_t pd, input word_t d);
    wr_en[p]   = 1'b1;
    wr_pd[p]   = pd;
    wr_data[p] = d;
  endtask

  task automatic alloc(input preg_t pd);
    alloc_en[0] = 1'b1;
    alloc_pd[0] = pd;
  endtask

  // Drives one read operand and queues what it must return this cycle.
  task automatic rd(input int p, input bit op2, input preg_t t, input bit en,
                    input word_t ed, input logic er, input string nm);
    exp_t e;
    rd_en[p] = en;
    if (op2) ps2[p] = t;
    else     ps1[p] = t;
    e.port = p; e.op2 = op2; e.d = ed; e.r = er; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t  e;
    word_t gd;
    logic  gr;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.op2) begin gd = d2[e.port]; gr = r2[e.port]; end
      else       begin gd = d1[e.port]; gr = r1[e.port]; end
      chk({e.nm, ".data"}, gd, e.d);
      chk({e.nm, ".rdy"}, {31'b0, gr}, {31'b0, e.r});
    end
  endtask

  // Check at the falling edge, then advance past the next rising edge.
  task automatic settle();
    @(negedge clk);
    drain();
    chk("collision", {31'b0, collision}, {31'b0, exp_coll});
    @(posedge clk);
    #1;
    idle();
  endtask

  function automatic void mread(input preg_t t, output word_t d, output logic r);
    d = m_data[t[3:0]];
    r = m_rdy[t[3:0]];
    for (int w = 0; w < 3; w++) begin
      if (wr_en[w] && wr_pd[w] == t) begin
        d = wr_data[w];
        r = 1'b1;
      end
    end
    if (t == '0) begin
      d = '0;
      r = 1'b1;
    end
  endfunction

  function automatic void mupdate();
    for (int w = 0; w < 3; w++) begin
      if (wr_en[w] && wr_pd[w] != '0) begin
        m_data[wr_pd[w][3:0]] = wr_data[w];
        m_rdy[wr_pd[w][3:0]]  = 1'b1;
      end
    end
    if (alloc_en[0] && alloc_pd[0] != '0) m_rdy[alloc_pd[0][3:0]] = 1'b0;
    if (flush) for (int i = 0; i < 16; i++) m_rdy[i] = 1'b1;
    for (int i = 0; i < 3; i++)
      for (int j = i + 1; j < 3; j++)
        if (wr_en[i] && wr_en[j] && wr_pd[i] == wr_pd[j] && wr_pd[i] != '0) m_coll = 1'b1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    exp_coll = 1'b0;
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Preload tag 5 so reset has something to wipe.
    wr(0, 5, 32'h0000_00AA);
    rd(0, 0, 5, 1, 32'h0000_00AA, 1'b1, "pre_byp");
    settle();
    rd(0, 0, 5, 1, 32'h0000_00AA, 1'b1, "pre_arr");
    settle();

    // Reset asserted mid-cycle with traffic present.
    reset_n = 1'b0;
    wr(0, 5, 32'h0000_00BB);
    alloc(9);
    rd(0, 0, 5, 1, 32'h0, 1'b0, "rst_p0a");
    rd(0, 1, 0, 1, 32'h0, 1'b0, "rst_p0b");
    rd(1, 0, 5, 1, 32'h0, 1'b0, "rst_p1");
    rd(2, 1, 9, 1, 32'h0, 1'b0, "rst_p2");
    settle();
    reset_n = 1'b1;
    wr(1, 6, 32'h0000_0066);
    rd(0, 0, 5, 1, 32'h0, 1'b1, "post_rst5");
    rd(1, 1, 0, 1, 32'h0, 1'b1, "post_rst0");
    rd(2, 0, 9, 1, 32'h0, 1'b1, "post_rst9");
    settle();
    rd(0, 0, 6, 1, 32'h0000_0066, 1'b1, "first_edge");
    settle();

    // Write with same-cycle bypass, then array read.
    wr(0, 10, 32'hDEAD_BEEF);
    rd(1, 0, 10, 1, 32'hDEAD_BEEF, 1'b1, "byp10");
    rd(2, 1, 10, 0, 32'h0, 1'b1, "byp10_noen");
    settle();
    rd(1, 0, 10, 1, 32'hDEAD_BEEF, 1'b1, "arr10");
    rd(0, 1, 10, 1, 32'hDEAD_BEEF, 1'b1, "arr10_p0");
    settle();

    // Tag 0 is hardwired and never collides.
    for (int p = 0; p < 3; p++) wr(p, 0, 32'h0000_1234);
    for (int p = 0; p < 3; p++) rd(p, 0, 0, 1, 32'h0, 1'b1, "tag0_byp");
    settle();
    rd(0, 0, 0, 1, 32'h0, 1'b1, "tag0_arr");
    settle();

    // Same-tag collision: highest port wins, flag is sticky.
    wr(0, 7, 32'h11);
    wr(2, 7, 32'h22);
    rd(0, 0, 7, 1, 32'h22, 1'b1, "coll_byp");
    settle();
    exp_coll = 1'b1;
    rd(0, 0, 7, 1, 32'h22, 1'b1, "coll_arr");
    settle();
    settle();
    settle();

    // Allocation and writeback ordering.
    alloc(20);
    rd(0, 0, 20, 1, 32'h0, 1'b1, "alloc_same");
    settle();
    rd(0, 0, 20, 1, 32'h0, 1'b0, "alloc_next");
    settle();
    wr(1, 20, 32'h55);
    rd(2, 0, 20, 1, 32'h55, 1'b1, "wb_byp");
    settle();
    rd(2, 0, 20, 1, 32'h55, 1'b1, "wb_arr");
    settle();
    alloc(21);
    wr(0, 21, 32'h56);
    rd(1, 1, 21, 1, 32'h56, 1'b1, "aw_byp");
    settle();
    rd(1, 1, 21, 1, 32'h56, 1'b0, "aw_arr");
    settle();

    // Flush overrides same-cycle allocation; flush-cycle writes still land.
    alloc(30);
    settle();
    alloc(31);
    rd(0, 0, 30, 1, 32'h0, 1'b0, "fl_pre30");
    rd(1, 0, 31, 1, 32'h0, 1'b1, "fl_pre31");
    settle();
    flush = 1'b1;
    alloc(40);
    wr(1, 41, 32'h77);
    rd(0, 0, 30, 1, 32'h0, 1'b0, "fl_same30");
    rd(1, 0, 31, 1, 32'h0, 1'b0, "fl_same31");
    settle();
    rd(0, 0, 30, 1, 32'h0, 1'b1, "fl_30");
    rd(1, 0, 31, 1, 32'h0, 1'b1, "fl_31");
    rd(2, 0, 40, 1, 32'h0, 1'b1, "fl_40");
    rd(0, 1, 41, 1, 32'h77, 1'b1, "fl_41");
    settle();

    // Reset again mid-traffic, then randomized run against the model.
    reset_n  = 1'b0;
    exp_coll = 1'b0;
    wr(2, 3, 32'h0000_0333);
    rd(0, 0, 3, 1, 32'h0, 1'b0, "rst2");
    settle();
    reset_n = 1'b1;
    m_coll  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_data[i] = '0;
      m_rdy[i]  = 1'b1;
    end

    for (int c = 0; c < 80; c++) begin
      for (int w = 0; w < 3; w++)
        if ($urandom_range(1, 0) == 1) wr(w, preg_t'($urandom_range(15, 0)), $urandom);
      if ($urandom_range(3, 0) == 0) alloc(preg_t'($urandom_range(15, 0)));
      flush = ($urandom_range(15, 0) == 0);
      for (int p = 0; p < 3; p++) begin
        bit    en;
        preg_t t;
        word_t md;
        logic  mr;
        en = ($urandom_range(3, 0) != 0);
        t  = preg_t'($urandom_range(15, 0));
        mread(t, md, mr);
        rd(p, 0, t, en, en ? md : 32'h0, mr, "rnd_op1");
        t = preg_t'($urandom_range(15, 0));
        mread(t, md, mr);
        rd(p, 1, t, en, en ? md : 32'h0, mr, "rnd_op2");
      end
      exp_coll = m_coll;
      mupdate();
      settle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
